alu_uart_ctrl: RTL and testbench
================================

Name: alu_uart_ctrl

Overview:
Command sequencer between a UART byte stream and the existing combinational ALU. It collects three bytes in order: operand A, operand B, then opcode. It validates the opcode, presents the operands to the ALU for one execute cycle, captures the result and hands it to the UART transmitter over a start/done handshake. It replaces the button-driven load path (btn_A/btn_B/btn_Op) when the board is driven from a host PC.

Parameters:
DATA_LENGTH, 8, width of operands, result, rx/tx bytes
OP_LENGTH, 6, width of ALU opcode field (low bits of the opcode byte)
TIMEOUT_CYCLES, 50000000, idle clk cycles allowed between bytes of one frame before the frame is abandoned

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
rx_data  in  DATA_LENGTH  byte from UART receiver, valid when rx_done=1
rx_done  in  1  one-cycle pulse, new byte on rx_data
tx_done  in  1  one-cycle pulse, transmitter finished the byte
alu_result  in  DATA_LENGTH  combinational ALU output
alu_a  out  DATA_LENGTH  operand A register to ALU
alu_b  out  DATA_LENGTH  operand B register to ALU
alu_op  out  OP_LENGTH  opcode register to ALU
tx_data  out  DATA_LENGTH  byte to transmitter
tx_start  out  1  one-cycle pulse, start transmission
busy  out  1  high in EXEC, SEND, WAIT_TX
op_err  out  1  one-cycle pulse, invalid opcode rejected
timeout  out  1  one-cycle pulse, partial frame abandoned

Behaviour:
- Reset (async, any state): state=WAIT_A; alu_a, alu_b, alu_op, tx_data=0; tx_start, op_err, timeout=0; busy=0; timeout counter=0.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A: on rx_done, alu_a<=rx_data, go to WAIT_B.
- WAIT_B: on rx_done, alu_b<=rx_data, go to WAIT_OP.
- WAIT_OP: on rx_done, check rx_data[OP_LENGTH-1:0]. Valid set is 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x02 SRA, 0x03 SRL. The upper bits of the byte must be 0.
  - Valid: alu_op<=opcode, go to EXEC.
  - Invalid: alu_op unchanged, op_err pulse the next cycle, go to WAIT_A.
- EXEC: one cycle with operands stable. tx_data<=alu_result, go to SEND.
- SEND: tx_start=1 for exactly this cycle, go to WAIT_TX.
- WAIT_TX: tx_data held stable. On tx_done, go to WAIT_A.
- Latency: opcode rx_done at cycle N -> EXEC at N+1 -> tx_start high at N+2.
- alu_a, alu_b and alu_op hold their values after a frame until overwritten. The ALU output therefore stays valid on the LEDs.
- Timeout counter:
  - Counts only in WAIT_B and WAIT_OP.
  - Clears on every accepted byte and on entry to WAIT_A.
  - At count TIMEOUT_CYCLES-1 without rx_done: timeout pulse next cycle, go to WAIT_A. Operand registers keep their partial values.
- Simultaneous events:
  - rx_done on the timeout expiry cycle: the byte wins (accepted, counter cleared, no timeout).
  - rx_done during EXEC, SEND or WAIT_TX: byte dropped silently, including when it coincides with tx_done.
  - tx_done outside WAIT_TX: ignored.
- No byte is ever buffered. The host must wait for the result byte before sending the next frame.

Decomposition:
- alu_defs.vh holds the shared constants: opcode localparams (ADD..SRL), state encodings, and DATA_LENGTH/OP_LENGTH defaults. The ALU and this block share it.
- One sub-module, frame_timeout: a counter with clear/enable inputs and an expire pulse output, parameterised by TIMEOUT_CYCLES. Its width is $clog2(TIMEOUT_CYCLES).
- The FSM and registers stay in alu_uart_ctrl.

Test Plan:
- Frame 0x05, 0x03, 0x20 -> alu_a=0x05, alu_b=0x03, alu_op=0x20; tx_start exactly 2 cycles after the third rx_done; tx_data=0x08; busy high until tx_done.
- Frames 0x03,0x05,0x22 (SUB) then 0x80,0x02,0x02 (SRA) -> tx_data 0xFE then 0xE0. Second frame accepted only after the first tx_done.
- Frame 0x05, 0x03, 0x21 (invalid) -> op_err one-cycle pulse, no tx_start, alu_op keeps its previous value, state back to WAIT_A. The next valid frame works normally.
- TIMEOUT_CYCLES=16, send 0x11 then silence -> timeout pulse after 16 cycles, state WAIT_A. A new 3-byte frame then executes from a fresh A.
- Byte sent during WAIT_TX, plus rx_done on the same cycle as tx_done -> both bytes dropped, alu_a unchanged, state WAIT_A.
- Assert reset in WAIT_TX -> all outputs zero immediately (async, before the next clk edge), tx_start never pulses again for that frame.

Source files
------------

// File: rtl/alu_uart_ctrl_pkg.sv
// Shared constants for the UART command sequencer: default widths,
// ALU opcode encodings, FSM state encoding and the opcode validity check.
package alu_uart_ctrl_pkg;

  localparam int DATA_LENGTH_DEF    = 8;
  localparam int OP_LENGTH_DEF      = 6;
  localparam int TIMEOUT_CYCLES_DEF = 50000000;

  localparam logic [OP_LENGTH_DEF-1:0] OP_ADD = 6'h20;
  localparam logic [OP_LENGTH_DEF-1:0] OP_SUB = 6'h22;
  localparam logic [OP_LENGTH_DEF-1:0] OP_AND = 6'h24;
  localparam logic [OP_LENGTH_DEF-1:0] OP_OR  = 6'h25;
  localparam logic [OP_LENGTH_DEF-1:0] OP_XOR = 6'h26;
  localparam logic [OP_LENGTH_DEF-1:0] OP_NOR = 6'h27;
  localparam logic [OP_LENGTH_DEF-1:0] OP_SRA = 6'h02;
  localparam logic [OP_LENGTH_DEF-1:0] OP_SRL = 6'h03;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  // True when the opcode field names an operation the ALU implements.
  function automatic logic is_valid_op(input logic [OP_LENGTH_DEF-1:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_uart_ctrl_frame_timeout.sv
// Inter-byte idle counter. Counts while enabled, restarts on clear, and
// flags expire during the cycle the count sits at TIMEOUT_CYCLES-1.
module frame_timeout
  import alu_uart_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_r;

  // Idle counter: clear wins over enable so an accepted byte restarts the window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = enable && (count_r == LAST);

endmodule

// File: rtl/alu_uart_ctrl.sv
// Command sequencer between a UART byte stream and the combinational ALU.
// Collects A, B and opcode bytes, runs one execute cycle, and hands the
// result byte to the transmitter over a start/done handshake.
module alu_uart_ctrl
  import alu_uart_ctrl_pkg::*;
#(
  parameter int DATA_LENGTH    = DATA_LENGTH_DEF,
  parameter int OP_LENGTH      = OP_LENGTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_LENGTH-1:0] rx_data,
  input  logic                   rx_done,
  input  logic                   tx_done,
  input  logic [DATA_LENGTH-1:0] alu_result,
  output logic [DATA_LENGTH-1:0] alu_a,
  output logic [DATA_LENGTH-1:0] alu_b,
  output logic [OP_LENGTH-1:0]   alu_op,
  output logic [DATA_LENGTH-1:0] tx_data,
  output logic                   tx_start,
  output logic                   busy,
  output logic                   op_err,
  output logic                   timeout
);

  state_t state_r, state_next_s;

  logic load_a_s, load_b_s, load_op_s, capture_s;
  logic op_err_s, timeout_s;
  logic expire_s, cnt_enable_s, cnt_clear_s;
  logic op_ok_s;

  // The whole byte must be a known opcode: upper bits above the field must be zero.
  assign op_ok_s = is_valid_op(rx_data[OP_LENGTH-1:0]) &&
                   (rx_data[DATA_LENGTH-1:OP_LENGTH] == '0);

  // Only the two mid-frame states are subject to the idle limit.
  assign cnt_enable_s = (state_r == ST_WAIT_B) || (state_r == ST_WAIT_OP);
  assign cnt_clear_s  = !cnt_enable_s || rx_done || timeout_s;

  frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear_s),
    .enable(cnt_enable_s),
    .expire(expire_s)
  );

  // Next-state and strobe decode; a received byte always beats a timeout.
  always_comb begin
    state_next_s = state_r;
    load_a_s     = 1'b0;
    load_b_s     = 1'b0;
    load_op_s    = 1'b0;
    capture_s    = 1'b0;
    op_err_s     = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      ST_WAIT_A: begin
        if (rx_done) begin
          load_a_s     = 1'b1;
          state_next_s = ST_WAIT_B;
        end else begin
          state_next_s = ST_WAIT_A;
        end
      end
      ST_WAIT_B: begin
        if (rx_done) begin
          load_b_s     = 1'b1;
          state_next_s = ST_WAIT_OP;
        end else if (expire_s) begin
          timeout_s    = 1'b1;
          state_next_s = ST_WAIT_A;
        end else begin
          state_next_s = ST_WAIT_B;
        end
      end
      ST_WAIT_OP: begin
        if (rx_done) begin
          if (op_ok_s) begin
            load_op_s    = 1'b1;
            state_next_s = ST_EXEC;
          end else begin
            op_err_s     = 1'b1;
            state_next_s = ST_WAIT_A;
          end
        end else if (expire_s) begin
          timeout_s    = 1'b1;
          state_next_s = ST_WAIT_A;
        end else begin
          state_next_s = ST_WAIT_OP;
        end
      end
      ST_EXEC: begin
        capture_s    = 1'b1;
        state_next_s = ST_SEND;
      end
      ST_SEND: begin
        state_next_s = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (tx_done) begin
          state_next_s = ST_WAIT_A;
        end else begin
          state_next_s = ST_WAIT_TX;
        end
      end
      default: begin
        state_next_s = ST_WAIT_A;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_WAIT_A;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand, opcode and result registers; operands persist between frames for the LEDs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      tx_data <= '0;
    end else begin
      if (load_a_s)  alu_a   <= rx_data;
      if (load_b_s)  alu_b   <= rx_data;
      if (load_op_s) alu_op  <= rx_data[OP_LENGTH-1:0];
      if (capture_s) tx_data <= alu_result;
    end
  end

  // Registered status outputs derived from the upcoming state and strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_start <= 1'b0;
      busy     <= 1'b0;
      op_err   <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      tx_start <= (state_next_s == ST_SEND);
      busy     <= (state_next_s == ST_EXEC) || (state_next_s == ST_SEND) ||
                  (state_next_s == ST_WAIT_TX);
      op_err   <= op_err_s;
      timeout  <= timeout_s;
    end
  end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl: a table of frames plus hand-written
// sequences for timeout, dropped bytes and reset during transmission.
module tb_alu_uart_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] alu_result;
  logic [7:0] alu_a, alu_b, tx_data;
  logic [5:0] alu_op;
  logic       tx_start, busy, op_err, timeout;

  int errors = 0;
  int checks = 0;

  alu_uart_ctrl #(
    .DATA_LENGTH(8),
    .OP_LENGTH(6),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .tx_done(tx_done), .alu_result(alu_result), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .tx_data(tx_data), .tx_start(tx_start), .busy(busy),
    .op_err(op_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Stand-in for the board's combinational ALU.
  always_comb begin
    case (alu_op)
      6'h20:   alu_result = alu_a + alu_b;
      6'h22:   alu_result = alu_a - alu_b;
      6'h24:   alu_result = alu_a & alu_b;
      6'h25:   alu_result = alu_a | alu_b;
      6'h26:   alu_result = alu_a ^ alu_b;
      6'h27:   alu_result = ~(alu_a | alu_b);
      6'h02:   alu_result = 8'($signed(alu_a) >>> alu_b);
      6'h03:   alu_result = alu_a >> alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opb;
    logic       valid;
    logic [7:0] exp_tx;
    logic [5:0] exp_op;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    send(v.a);
    send(v.b);
    send(v.opb);
    if (v.valid) begin
      chk("exec_busy", busy, 1);
      chk("exec_no_start", tx_start, 0);
      @(negedge clk);
      chk("tx_start", tx_start, 1);
      chk("tx_data", tx_data, v.exp_tx);
      chk("alu_a", alu_a, v.a);
      chk("alu_b", alu_b, v.b);
      chk("alu_op", alu_op, v.exp_op);
      @(negedge clk);
      chk("tx_start_single", tx_start, 0);
      repeat (3) @(negedge clk);
      chk("wait_tx_busy", busy, 1);
      chk("wait_tx_hold", tx_data, v.exp_tx);
      pulse_tx_done();
      chk("idle_busy", busy, 0);
    end else begin
      chk("op_err_pulse", op_err, 1);
      chk("err_busy", busy, 0);
      chk("err_alu_op_kept", alu_op, v.exp_op);
      @(negedge clk);
      chk("op_err_single", op_err, 0);
      chk("err_no_start", tx_start, 0);
    end
  endtask

  initial begin
    logic saw_start;
    vec_t v;

    vecs[0] = '{8'h05, 8'h03, 8'h20, 1'b1, 8'h08, 6'h20};
    vecs[1] = '{8'h03, 8'h05, 8'h22, 1'b1, 8'hFE, 6'h22};
    vecs[2] = '{8'h80, 8'h02, 8'h02, 1'b1, 8'hE0, 6'h02};
    vecs[3] = '{8'h05, 8'h03, 8'h21, 1'b0, 8'h00, 6'h02};
    vecs[4] = '{8'hF0, 8'h3C, 8'h24, 1'b1, 8'h30, 6'h24};
    vecs[5] = '{8'hF0, 8'h0F, 8'h25, 1'b1, 8'hFF, 6'h25};
    vecs[6] = '{8'hFF, 8'h0F, 8'h26, 1'b1, 8'hF0, 6'h26};
    vecs[7] = '{8'hF0, 8'h0F, 8'h27, 1'b1, 8'h00, 6'h27};
    vecs[8] = '{8'h05, 8'h03, 8'h60, 1'b0, 8'h00, 6'h27};
    vecs[9] = '{8'h80, 8'h03, 8'h03, 1'b1, 8'h10, 6'h03};

    reset = 1'b1; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_flags", {tx_start, busy, op_err, timeout}, 0);
    reset = 1'b0;

    // tx_done while idle must be ignored
    @(negedge clk);
    pulse_tx_done();
    chk("stray_tx_done", busy, 0);

    for (int i = 0; i < 10; i++) run_frame(vecs[i]);

    // Partial frame then silence: timeout after 16 idle cycles
    send(8'h11);
    repeat (15) @(negedge clk);
    chk("timeout_early", timeout, 0);
    @(negedge clk);
    chk("timeout_pulse", timeout, 1);
    chk("timeout_alu_a_kept", alu_a, 8'h11);
    @(negedge clk);
    chk("timeout_single", timeout, 0);
    v = '{8'h01, 8'h02, 8'h20, 1'b1, 8'h03, 6'h20};
    run_frame(v);

    // Byte arriving on the expiry cycle is accepted, no timeout
    send(8'h07);
    repeat (14) @(negedge clk);
    send(8'h09);
    chk("expiry_byte_wins", timeout, 0);
    chk("expiry_alu_b", alu_b, 8'h09);
    send(8'h20);
    @(negedge clk);
    chk("expiry_frame_start", tx_start, 1);
    chk("expiry_frame_data", tx_data, 8'h10);
    @(negedge clk);

    // Bytes during WAIT_TX, including one coinciding with tx_done, are dropped
    send(8'h77);
    chk("drop_alu_a", alu_a, 8'h07);
    @(negedge clk);
    rx_data = 8'h99; rx_done = 1'b1; tx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; tx_done = 1'b0;
    chk("drop_coincident_alu_a", alu_a, 8'h07);
    chk("drop_idle", busy, 0);
    v = '{8'h0A, 8'h05, 8'h22, 1'b1, 8'h05, 6'h22};
    run_frame(v);

    // Reset while in WAIT_TX clears outputs asynchronously
    send(8'h05); send(8'h03); send(8'h20);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_alu_a", alu_a, 0);
    chk("async_rst_alu_op", alu_op, 0);
    chk("async_rst_tx_data", tx_data, 0);
    chk("async_rst_flags", {tx_start, busy, op_err, timeout}, 0);
    @(negedge clk);
    reset = 1'b0;
    saw_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tx_start) saw_start = 1'b1;
    end
    chk("no_start_after_reset", saw_start, 0);
    v = '{8'h80, 8'h01, 8'h03, 1'b1, 8'h40, 6'h03};
    run_frame(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
